// File: rtl/bobc_inverso_if.sv
// Handshake and operand bundle for the BOBC inverse search block.
interface bobc_inverso_if #(
  parameter int XW = 8,
  parameter int DW = 16
);
  logic          inicio;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [DW-1:0] C;
  logic [DW-1:0] y;
  logic [XW-1:0] x_out;
  logic          achou;
  logic          pronto;
  logic          ocupado;

  modport master (
    output inicio, A, B, C, y,
    input  x_out, achou, pronto, ocupado
  );

  modport slave (
    input  inicio, A, B, C, y,
    output x_out, achou, pronto, ocupado
  );
endinterface

// File: rtl/bobc_inverso.sv
// Finds the smallest x with A*x^2 + B*x + C == y (mod 2^DW) by scanning x
// upward and evaluating each candidate with a two-step Horner datapath.
module bobc_inverso #(
  parameter int XW = 8,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  bobc_inverso_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_CMP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic [DW-1:0] y_q, y_d;
  logic [DW-1:0] h_q, h_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] x_out_q, x_out_d;
  logic          achou_q, achou_d;
  logic [DW-1:0] x_ext;

  assign x_ext = {{(DW-XW){1'b0}}, x_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      y_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      x_out_q <= '0;
      achou_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      y_q     <= y_d;
      h_q     <= h_d;
      x_q     <= x_d;
      x_out_q <= x_out_d;
      achou_q <= achou_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    y_d     = y_q;
    h_d     = h_q;
    x_d     = x_q;
    x_out_d = x_out_q;
    achou_d = achou_q;
    case (state_q)
      S_IDLE: begin
        if (bus.inicio) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.C;
          y_d     = bus.y;
          x_d     = '0;
          achou_d = 1'b0;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        h_d     = a_q * x_ext + b_q;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        h_d     = h_q * x_ext + c_q;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (h_q == y_q) begin
          achou_d = 1'b1;
          x_out_d = x_q;
          state_d = S_DONE;
        end else if (x_q == '1) begin
          achou_d = 1'b0;
          x_out_d = x_q;
          state_d = S_DONE;
        end else begin
          x_d     = x_q + XW'(1);
          state_d = S_MUL1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.x_out   = x_out_q;
  assign bus.achou   = achou_q;
  assign bus.pronto  = (state_q == S_DONE);
  assign bus.ocupado = (state_q != S_IDLE);

endmodule

// File: tb/tb_bobc_inverso.sv
// Self-checking bench for bobc_inverso: vector table plus scoreboard of
// expected {x_out, achou, latency} popped at each pronto pulse.
module tb_bobc_inverso;
  localparam int XW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  bobc_inverso_if #(.XW(XW), .DW(DW)) bus();
  bobc_inverso #(.XW(XW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] a, b, c, y;
    logic [XW-1:0] x;
    bit            f;
  } vec_t;

  typedef struct {
    logic [XW-1:0] x;
    bit            f;
    int unsigned   lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Direct polynomial form, deliberately not Horner.
  function automatic void model(input logic [DW-1:0] a, b, c, y,
                                output logic [XW-1:0] x, output bit f);
    logic [DW-1:0] xv, v;
    f = 1'b0;
    x = '1;
    for (int unsigned i = 0; i < (1 << XW); i++) begin
      xv = DW'(i);
      v  = a * xv * xv + b * xv + c;
      if (v == y) begin
        x = XW'(i);
        f = 1'b1;
        break;
      end
    end
  endfunction

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.x   = v.x;
    e.f   = v.f;
    e.lat = 3 * int'(v.x) + 3;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    bus.A = v.a;
    bus.B = v.b;
    bus.C = v.c;
    bus.y = v.y;
  endtask

  task automatic start(input string name, input vec_t v, output int unsigned sc);
    @(negedge clk);
    drive(v);
    bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    bus.inicio = 1'b0;
    sb.push_back(mk_exp(v));
    check({name, " busy_after_start"}, bus.ocupado, 1);
    check({name, " achou_cleared"}, bus.achou, 0);
  endtask

  task automatic wait_done(input string name, input int unsigned sc);
    int   busy_bad = 0;
    bit   ok = 1'b0;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (bus.ocupado !== 1'b1) busy_bad++;
      if (bus.pronto === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " ocupado_during"}, busy_bad, 0);
    check({name, " pronto_seen"}, ok, 1);
    if (sb.size() == 0) begin
      check({name, " scoreboard_entry"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!ok) return;
    check({name, " x_out"}, bus.x_out, e.x);
    check({name, " achou"}, bus.achou, e.f);
    check({name, " latency"}, cyc - sc, e.lat);
    @(posedge clk);
    #1;
    check({name, " pronto_one_cycle"}, bus.pronto, 0);
    check({name, " idle_after"}, bus.ocupado, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    vec_t        v;
    int unsigned sc;
    int          pulses;
    logic [XW-1:0] x0;

    tbl[0] = '{a: 16'd5, b: 16'd3, c: 16'd4, y: 16'd30,    x: 8'd2,   f: 1'b1};
    tbl[1] = '{a: 16'd5, b: 16'd3, c: 16'd4, y: 16'd4,     x: 8'd0,   f: 1'b1};
    tbl[2] = '{a: 16'd0, b: 16'd0, c: 16'd4, y: 16'd5,     x: 8'd255, f: 1'b0};
    tbl[3] = '{a: 16'd4, b: 16'd0, c: 16'd1, y: 16'd2065,  x: 8'd130, f: 1'b1};
    tbl[4] = '{a: 16'd0, b: 16'd1, c: 16'd0, y: 16'd255,   x: 8'd255, f: 1'b1};
    tbl[5] = '{a: 16'd1, b: 16'd2, c: 16'd3, y: 16'd40403, x: 8'd200, f: 1'b1};

    rst = 1'b1;
    bus.inicio = 1'b0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset x_out", bus.x_out, 0);
    check("reset achou", bus.achou, 0);
    check("reset pronto", bus.pronto, 0);
    check("reset ocupado", bus.ocupado, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start(nm, tbl[i], sc);
      wait_done(nm, sc);
      repeat (3) @(posedge clk);
      #1;
      check({nm, " x_out_held"}, bus.x_out, tbl[i].x);
      check({nm, " achou_held"}, bus.achou, tbl[i].f);
    end

    for (int i = 0; i < 3; i++) begin
      string nm;
      nm = $sformatf("rand%0d", i);
      v.a = DW'($urandom);
      v.b = DW'($urandom);
      v.c = DW'($urandom);
      x0  = XW'($urandom_range(0, 255));
      v.y = v.a * DW'(x0) * DW'(x0) + v.b * DW'(x0) + v.c;
      model(v.a, v.b, v.c, v.y, v.x, v.f);
      start(nm, v, sc);
      wait_done(nm, sc);
    end

    // Reset at edge 100 of a full scan must abort without a pronto pulse.
    start("rstmid", tbl[2], sc);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("rstmid ocupado", bus.ocupado, 0);
    check("rstmid pronto", bus.pronto, 0);
    check("rstmid achou", bus.achou, 0);
    check("rstmid x_out", bus.x_out, 0);
    pulses = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) pulses++;
    end
    check("rstmid no_activity", pulses, 0);
    start("post_rst", tbl[0], sc);
    wait_done("post_rst", sc);

    // inicio held high and operands changed mid-search; restart only from IDLE.
    @(negedge clk);
    drive(tbl[0]);
    bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    sb.push_back(mk_exp(tbl[0]));
    drive(tbl[1]);
    wait_done("hold", sc);
    @(posedge clk);
    #1;
    sc = cyc;
    bus.inicio = 1'b0;
    check("hold restart_busy", bus.ocupado, 1);
    check("hold restart_achou_cleared", bus.achou, 0);
    sb.push_back(mk_exp(tbl[1]));
    wait_done("hold2", sc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
